// File: rtl/alu_op_sequencer_if.sv
// Request handshake bundle between a requester and alu_op_sequencer.
// A request transfers on any rising clk edge where req_valid & req_ready are both high.
interface alu_op_sequencer_if #(
   parameter int W_OP   = 5,
   parameter int W_DATA = 8
);
   logic              req_valid;
   logic              req_ready;
   logic [W_OP-1:0]   req_op;
   logic [W_DATA-1:0] req_src;
   logic [W_DATA-1:0] req_src_hi;
   logic              req_wide;
   logic              req_load;

   modport master (
      output req_valid, req_op, req_src, req_src_hi, req_wide, req_load,
      input  req_ready
   );

   modport slave (
      input  req_valid, req_op, req_src, req_src_hi, req_wide, req_load,
      output req_ready
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// Requester side of alu_8: owns {acc_hi,acc} and F, sequences narrow/wide ADD/SUB passes.
// Optional opcode checking is enabled by defining ALU_SEQ_OPCHK_EN.
module alu_op_sequencer #(
   parameter int W_OP   = 5,
   parameter int W_DATA = 8
) (
   input  logic              clk,
   input  logic              reset,
   alu_op_sequencer_if.slave req,
   output logic [W_DATA-1:0] alu_a,
   output logic [W_DATA-1:0] alu_b,
   output logic [W_OP-1:0]   alu_op,
   input  logic [W_DATA-1:0] alu_out,
   input  logic [W_DATA-1:0] alu_flags,
   output logic [W_DATA-1:0] acc,
   output logic [W_DATA-1:0] acc_hi,
   output logic [W_DATA-1:0] flags,
   output logic              done,
   output logic              err,
   output logic [2:0]        state_dbg
);

   localparam int F_S  = 7;
   localparam int F_Z  = 6;
   localparam int F_H  = 4;
   localparam int F_PV = 2;
   localparam int F_N  = 1;
   localparam int F_C  = 0;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LO   = 3'd1,
      HI   = 3'd2,
      HI_C = 3'd3,
      CMT  = 3'd4
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              accept;
   logic              wide_ok;
   logic              bad_op;
   logic              wide_q;
   logic              lo_c_q;
   logic [W_DATA-1:0] src_hi_q;
   logic [W_DATA-1:0] lo_res_q;
   logic [W_DATA-1:0] hi_flags_q;

   assign accept  = req.req_valid & req.req_ready;
   assign wide_ok = req.req_wide & ((req.req_op == W_OP'(0)) | (req.req_op == W_OP'(1)));

   always_comb begin
      bad_op = 1'b0;
`ifdef ALU_SEQ_OPCHK_EN
      bad_op = (req.req_op == W_OP'(5))  | (req.req_op == W_OP'(12)) |
               (req.req_op == W_OP'(13)) | (req.req_op >= W_OP'(17)) |
               (req.req_wide & ~wide_ok);
`endif
   end

   // Wide F: sign from the last pass, zero over all 16 bits, overflow/carry OR'd across
   // the HI pass (hi_f) and the carry-fix pass (fin_f); both are the same flags without HI_C.
   function automatic logic [W_DATA-1:0] wide_flags(
      input logic [W_DATA-1:0] hi_f,
      input logic [W_DATA-1:0] fin_f,
      input logic [W_DATA-1:0] hi_byte,
      input logic [W_DATA-1:0] lo_byte,
      input logic              is_sub
   );
      logic [W_DATA-1:0] f;
      f       = hi_f;
      f[F_S]  = fin_f[F_S];
      f[F_Z]  = (hi_byte == '0) & (lo_byte == '0);
      f[F_H]  = hi_f[F_H];
      f[F_PV] = hi_f[F_PV] | fin_f[F_PV];
      f[F_N]  = is_sub;
      f[F_C]  = hi_f[F_C] | fin_f[F_C];
      return f;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, CMT: begin
            if (!accept)           state_nxt = IDLE;
            else if (req.req_load) state_nxt = CMT;
            else if (bad_op)       state_nxt = IDLE;
            else                   state_nxt = LO;
         end
         LO:      state_nxt = wide_q ? HI : CMT;
         HI:      state_nxt = lo_c_q ? HI_C : CMT;
         HI_C:    state_nxt = CMT;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req.req_ready = (state == IDLE) | (state == CMT);
      done          = (state == CMT);
      state_dbg     = state;
   end

   // Datapath: operands are registered on entry to each pass so alu_* never see req_* directly.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc        <= '0;
         acc_hi     <= '0;
         flags      <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_op     <= '0;
         wide_q     <= 1'b0;
         lo_c_q     <= 1'b0;
         src_hi_q   <= '0;
         lo_res_q   <= '0;
         hi_flags_q <= '0;
      end else begin
         case (state)
            IDLE, CMT: begin
               if (accept) begin
                  if (req.req_load) begin
                     acc    <= req.req_src;
                     acc_hi <= req.req_src_hi;
                  end else if (!bad_op) begin
                     wide_q   <= wide_ok;
                     src_hi_q <= req.req_src_hi;
                     alu_a    <= acc;
                     alu_b    <= req.req_src;
                     alu_op   <= req.req_op;
                  end
               end
            end
            LO: begin
               if (wide_q) begin
                  lo_res_q <= alu_out;
                  lo_c_q   <= alu_flags[F_C];
                  alu_a    <= acc_hi;
                  alu_b    <= src_hi_q;
               end else begin
                  acc   <= alu_out;
                  flags <= alu_flags;
               end
            end
            HI: begin
               if (lo_c_q) begin
                  hi_flags_q <= alu_flags;
                  alu_a      <= alu_out;
                  alu_b      <= W_DATA'(1);
               end else begin
                  acc    <= lo_res_q;
                  acc_hi <= alu_out;
                  flags  <= wide_flags(alu_flags, alu_flags, alu_out, lo_res_q,
                                       alu_op == W_OP'(1));
               end
            end
            HI_C: begin
               acc    <= lo_res_q;
               acc_hi <= alu_out;
               flags  <= wide_flags(hi_flags_q, alu_flags, alu_out, lo_res_q,
                                    alu_op == W_OP'(1));
            end
            default: ;
         endcase
      end
   end

`ifdef ALU_SEQ_OPCHK_EN
   logic err_q;

   always_ff @(posedge clk) begin
      if (reset) err_q <= 1'b0;
      else       err_q <= accept & ~req.req_load & bad_op;
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule
